// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, types and select helper for the 1-to-9 distributor
package demux_pkg;

  localparam int NUM_LANES      = 9;
  localparam int SEL_W          = 4;
  localparam int DATA_W_DEFAULT = 16;
  localparam int ERR_W_DEFAULT  = 8;

  typedef logic [SEL_W-1:0]     sel_t;
  typedef logic [NUM_LANES-1:0] lane_vec_t;

  // A select addresses a real lane only when it is below the lane count.
  function automatic logic lane_valid(input sel_t sel);
    return int'(sel) < NUM_LANES;
  endfunction

endpackage

// File: rtl/demux1to9_dist_if.sv
// rtl/demux1to9_dist_if.sv - input word stream, nine output lanes and drop status
interface demux1to9_dist_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ERR_W  = ERR_W_DEFAULT
);

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_data;
  logic [SEL_W-1:0]              in_sel;
  logic [NUM_LANES-1:0]          out_valid;
  logic [NUM_LANES-1:0]          out_ready;
  logic [NUM_LANES*DATA_W-1:0]   out_data;
  logic                          drop_pulse;
  logic [ERR_W-1:0]              drop_cnt;

  // Producer of input words and consumer of all lanes.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, drop_pulse, drop_cnt
  );

  // The distributor itself.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, drop_pulse, drop_cnt
  );

endinterface

// File: rtl/lane_reg.sv
// rtl/lane_reg.sv - one-entry valid/ready holding register for a single output lane
module lane_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              drain,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  // Load wins over drain so a same-cycle refill keeps valid high with no bubble;
  // a plain drain clears valid but leaves the last word on q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to9_dist.sv
// rtl/demux1to9_dist.sv - registered 1-to-9 word distributor with per-lane backpressure
module demux1to9_dist
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ERR_W  = ERR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  demux1to9_dist_if.slave   bus
);

  lane_vec_t                   lane_full;
  lane_vec_t                   load;
  logic [DATA_W-1:0]           lane_q [NUM_LANES];
  logic [NUM_LANES*DATA_W-1:0] out_data_flat;
  logic                        sel_ok;
  logic                        in_ready;
  logic                        accept;
  logic                        drop;
  logic                        drop_pulse_q;
  logic [ERR_W-1:0]            drop_cnt_q;

  // Ready mux: an addressed lane can take a word if empty or draining this cycle;
  // invalid selects are always taken so they can be dropped.
  always_comb begin
    sel_ok   = lane_valid(bus.in_sel);
    in_ready = 1'b1;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (sel_ok && (bus.in_sel == sel_t'(k))) begin
        in_ready = !lane_full[k] || bus.out_ready[k];
      end
    end
  end

  // Select decode into a one-hot load vector plus the drop strobe.
  always_comb begin
    accept = bus.in_valid && in_ready;
    drop   = accept && !sel_ok;
    load   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      load[k] = accept && sel_ok && (bus.in_sel == sel_t'(k));
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_reg #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .data  (bus.in_data),
      .drain (bus.out_ready[k]),
      .valid (lane_full[k]),
      .q     (lane_q[k])
    );
  end

  // Pack the lane registers into the flat output bus, lane k at slice k.
  always_comb begin
    out_data_flat = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      out_data_flat[k*DATA_W +: DATA_W] = lane_q[k];
    end
  end

  // Drop strobe and saturating drop counter, both updated on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= drop;
      if (drop && (drop_cnt_q != {ERR_W{1'b1}})) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = lane_full;
  assign bus.out_data   = out_data_flat;
  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_demux1to9_dist.sv
// tb/tb_demux1to9_dist.sv - scoreboard bench for the 1-to-9 distributor
module tb_demux1to9_dist;
  import demux_pkg::*;

  localparam int DW = 16;
  localparam int EW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  demux1to9_dist_if #(.DATA_W(DW), .ERR_W(EW)) dif ();

  demux1to9_dist #(.DATA_W(DW), .ERR_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  typedef struct {
    int          lane;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lane_d(input int k);
    return dif.out_data[k*DW +: DW];
  endfunction

  // Monitor: every word leaving a lane is matched against the oldest expected word for that lane.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          if (dif.out_valid[k] && dif.out_ready[k]) begin
            int idx;
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
              if (sb[i].lane == k) begin
                idx = i;
                break;
              end
            end
            if (idx < 0) begin
              tests++;
              fails++;
              $display("FAIL drain_unexpected lane %0d: got %0h expected nothing", k, lane_d(k));
            end else begin
              chk($sformatf("drain_lane%0d", k), 144'(lane_d(k)), 144'(sb[idx].data));
              sb.delete(idx);
            end
          end
        end
      end
    end
  end

  // Drive one word from posedge+1, wait (bounded) for in_ready, record the expectation.
  task automatic send(input logic [3:0] sel, input logic [15:0] d);
    int n;
    n = 0;
    dif.in_valid = 1'b1;
    dif.in_sel   = sel;
    dif.in_data  = d;
    @(negedge clk);
    while (!dif.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!dif.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout sel %0d: got in_ready 0 expected 1", sel);
    end else if (lane_valid(sel)) begin
      sb.push_back('{lane: int'(sel), data: d});
    end
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.in_valid  = 1'b0;
    dif.in_sel    = 4'd0;
    dif.in_data   = 16'h0;
    dif.out_ready = 9'h000;

    // Reset state
    #12;
    chk("rst_out_valid",  144'(dif.out_valid),  144'(0));
    chk("rst_out_data",   144'(dif.out_data),   144'(0));
    chk("rst_drop_pulse", 144'(dif.drop_pulse), 144'(0));
    chk("rst_drop_cnt",   144'(dif.drop_cnt),   144'(0));
    chk("rst_in_ready",   144'(dif.in_ready),   144'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word to lane 3, stalled consumer
    send(4'd3, 16'hA5A5);
    @(negedge clk);
    chk("l3_valid", 144'(dif.out_valid), 144'(9'b000001000));
    chk("l3_data",  144'(lane_d(3)),     144'(16'hA5A5));
    @(posedge clk);
    #1;
    dif.in_valid = 1'b1;
    dif.in_sel   = 4'd3;
    dif.in_data  = 16'h1111;
    @(negedge clk);
    chk("l3_stall_ready0", 144'(dif.in_ready), 144'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("l3_stall_ready1", 144'(dif.in_ready), 144'(0));
    chk("l3_stall_data",   144'(lane_d(3)),    144'(16'hA5A5));
    @(posedge clk);
    #1;
    dif.out_ready = 9'h1FF;
    send(4'd3, 16'h1111);

    // Stream across all lanes with every consumer ready
    for (int k = 0; k < NUM_LANES; k++) begin
      dif.in_valid = 1'b1;
      dif.in_sel   = 4'(k);
      dif.in_data  = 16'h0010 + 16'(k);
      @(negedge clk);
      chk($sformatf("stream_ready%0d", k), 144'(dif.in_ready), 144'(1));
      if (k > 0) begin
        chk($sformatf("stream_valid%0d", k-1), 144'(dif.out_valid[k-1]), 144'(1));
        chk($sformatf("stream_data%0d", k-1),  144'(lane_d(k-1)), 144'(16'h0010 + 16'(k-1)));
      end
      if (dif.in_ready) sb.push_back('{lane: k, data: 16'h0010 + 16'(k)});
      @(posedge clk);
      #1;
    end
    dif.in_valid = 1'b0;
    @(negedge clk);
    chk("stream_valid8", 144'(dif.out_valid[8]), 144'(1));
    chk("stream_data8",  144'(lane_d(8)),        144'(16'h0018));
    @(posedge clk);
    #1;

    // Lane 5 held full does not block lane 2
    dif.out_ready = 9'h1DB;
    send(4'd5, 16'h5555);
    send(4'd2, 16'h2222);
    @(negedge clk);
    chk("iso_l5_valid", 144'(dif.out_valid[5]), 144'(1));
    chk("iso_l5_data",  144'(lane_d(5)),         144'(16'h5555));
    chk("iso_l2_valid", 144'(dif.out_valid[2]), 144'(1));
    chk("iso_l2_data",  144'(lane_d(2)),         144'(16'h2222));
    @(posedge clk);
    #1;
    dif.out_ready = 9'h1FF;

    // Lane 7 drain and refill in the same cycle
    dif.out_ready = 9'h17F;
    send(4'd7, 16'h7777);
    @(negedge clk);
    chk("l7_full", 144'(lane_d(7)), 144'(16'h7777));
    @(posedge clk);
    #1;
    dif.out_ready = 9'h1FF;
    send(4'd7, 16'hBEEF);
    @(negedge clk);
    chk("l7_nobubble", 144'(dif.out_valid[7]), 144'(1));
    chk("l7_beef",     144'(lane_d(7)),        144'(16'hBEEF));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_valid", 144'(dif.out_valid), 144'(0));

    // Invalid select is dropped and counted
    @(posedge clk);
    #1;
    dif.in_valid = 1'b1;
    dif.in_sel   = 4'hC;
    dif.in_data  = 16'h1234;
    @(negedge clk);
    chk("drop_in_ready", 144'(dif.in_ready), 144'(1));
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    @(negedge clk);
    chk("drop_pulse1",  144'(dif.drop_pulse), 144'(1));
    chk("drop_cnt1",    144'(dif.drop_cnt),   144'(1));
    chk("drop_nolane",  144'(dif.out_valid),  144'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drop_pulse_off", 144'(dif.drop_pulse), 144'(0));
    chk("drop_cnt_hold",  144'(dif.drop_cnt),   144'(1));
    @(posedge clk);
    #1;
    dif.in_valid = 1'b1;
    dif.in_sel   = 4'hF;
    repeat (300) @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    @(negedge clk);
    chk("drop_sat", 144'(dif.drop_cnt), 144'(255));
    chk("drop_sat_valid", 144'(dif.out_valid), 144'(0));

    // Asynchronous reset with lanes 1 and 8 full
    @(posedge clk);
    #1;
    dif.out_ready = 9'h000;
    send(4'd1, 16'h1111);
    send(4'd8, 16'h8888);
    @(negedge clk);
    chk("pre_rst_valid", 144'(dif.out_valid), 144'(9'h102));
    @(posedge clk);
    #1;
    dif.in_valid = 1'b1;
    dif.in_sel   = 4'd4;
    dif.in_data  = 16'h4444;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",      144'(dif.out_valid),  144'(0));
    chk("arst_data",       144'(dif.out_data),   144'(0));
    chk("arst_drop_cnt",   144'(dif.drop_cnt),   144'(0));
    chk("arst_drop_pulse", 144'(dif.drop_pulse), 144'(0));
    sb.delete();
    dif.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Drain anything left and confirm the scoreboard is empty
    dif.out_ready = 9'h1FF;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("final_sb_empty", 144'(sb.size()),     144'(0));
    chk("final_valid",    144'(dif.out_valid), 144'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
